// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU opcodes, main-control
// aluop encodings, branch funct3 codes, the decoded-op record and the
// branch-resolve helper.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    // ALU opcodes understood by the 64-bit ALU
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;

    // Main-control aluop field
    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_RSVD   = 2'b11
    } aluop_e;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // R-type funct3 codes that map onto the ALU
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_ORNOR  = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    // Result of decoding one instruction for the ALU
    typedef struct packed {
        logic [ALU_OP_W-1:0] op;
        logic                is_branch;
        logic                illegal;
        logic [2:0]          funct3;
    } dec_op_t;

    // Branch condition from the ALU flags of a SUB (a - b).
    // zero means a == b, geq means unsigned a >= b.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       zero,
                                          input logic       geq);
        logic taken;
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BGEU: taken = geq;
            F3_BLTU: taken = !geq;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decoder: main-control aluop plus funct3/funct7[5] into the
// 4-bit ALU opcode, with branch and illegal tags. Illegal ops always issue
// opcode 0000 so the ALU sees a harmless AND.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output dec_op_t    dec
);

    // Opcode and tag selection; defaults describe a legal AND with no tags
    always_comb begin
        dec           = '0;
        dec.funct3    = funct3;
        case (aluop)
            ALUOP_MEM: begin
                dec.op = ALU_ADD;
            end
            ALUOP_BRANCH: begin
                dec.is_branch = 1'b1;
                case (funct3)
                    F3_BEQ, F3_BNE, F3_BLTU, F3_BGEU: dec.op = ALU_SUB;
                    default:                          dec.illegal = 1'b1;
                endcase
            end
            ALUOP_RTYPE: begin
                case (funct3)
                    F3_ADDSUB: dec.op = funct7_5 ? ALU_SUB : ALU_ADD;
                    F3_AND:    dec.op = ALU_AND;
                    F3_ORNOR:  dec.op = funct7_5 ? ALU_NOR : ALU_OR;
                    default:   dec.illegal = 1'b1;
                endcase
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        if (dec.illegal) begin
            dec.op = ALU_AND;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue/resolve stage in front of the 64-bit ALU.
// Stage 1 decodes and registers operands/opcode that drive the ALU inputs;
// stage 2 captures the ALU result and resolves branches from ZERO/GEQ.
// Optional build macro ALU_ISSUE_STATS_EN adds branch statistics counters
// (stat_branches, stat_taken) counted on stage-2 handshakes of legal branches.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_aluop,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7_5,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              flush,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_geq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_is_branch,
    output logic              out_taken,
    output logic              out_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_taken
`endif
);

    // Stage 1 state: operands and opcode double as the ALU input registers
    logic              s1_valid_reg;
    logic [DATA_W-1:0] s1_a_reg;
    logic [DATA_W-1:0] s1_b_reg;
    logic [OP_W-1:0]   s1_op_reg;
    logic              s1_branch_reg;
    logic              s1_illegal_reg;
    logic [2:0]        s1_funct3_reg;

    // Stage 2 state: captured result and resolved tags
    logic              s2_valid_reg;
    logic [DATA_W-1:0] s2_result_reg;
    logic              s2_branch_reg;
    logic              s2_taken_reg;
    logic              s2_illegal_reg;

    logic              s2_adv;
    logic              s1_adv;
    logic              accept;
    logic              taken_next;
    dec_op_t           dec;

    alu_op_decode u_decode (
        .aluop    (in_aluop),
        .funct3   (in_funct3),
        .funct7_5 (in_funct7_5),
        .dec      (dec)
    );

    // Handshake: each stage moves when its successor has room.
    // in_ready ignores in_valid and flush; flush only suppresses the accept.
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv && !flush;

    // Branch outcome uses the stage-1 funct3 against the live ALU flags;
    // illegal ops and non-branches never report taken.
    assign taken_next = s1_branch_reg && !s1_illegal_reg &&
                        branch_taken(s1_funct3_reg, alu_zero, alu_geq);

    // Stage 1 register: load on advance, hold while stalled so the ALU
    // inputs stay stable; flush empties the stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg   <= 1'b0;
            s1_a_reg       <= '0;
            s1_b_reg       <= '0;
            s1_op_reg      <= '0;
            s1_branch_reg  <= 1'b0;
            s1_illegal_reg <= 1'b0;
            s1_funct3_reg  <= '0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_a_reg       <= in_a;
                s1_b_reg       <= in_b;
                s1_op_reg      <= dec.op;
                s1_branch_reg  <= dec.is_branch;
                s1_illegal_reg <= dec.illegal;
                s1_funct3_reg  <= dec.funct3;
            end
        end
    end

    // Stage 2 register: capture ALU result and resolved tags on advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_reg   <= 1'b0;
            s2_result_reg  <= '0;
            s2_branch_reg  <= 1'b0;
            s2_taken_reg   <= 1'b0;
            s2_illegal_reg <= 1'b0;
        end else if (flush) begin
            s2_valid_reg <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg   <= s1_valid_reg;
            s2_result_reg  <= alu_result;
            s2_branch_reg  <= s1_branch_reg;
            s2_taken_reg   <= taken_next;
            s2_illegal_reg <= s1_illegal_reg;
        end
    end

    assign alu_a         = s1_a_reg;
    assign alu_b         = s1_b_reg;
    assign alu_op        = s1_op_reg;
    assign out_valid     = s2_valid_reg;
    assign out_result    = s2_result_reg;
    assign out_is_branch = s2_branch_reg;
    assign out_taken     = s2_taken_reg;
    assign out_illegal   = s2_illegal_reg;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_taken_reg;
    logic        stat_hit;

    // A legal branch leaving stage 2 counts once; flush does not clear
    assign stat_hit = s2_valid_reg && out_ready && s2_branch_reg && !s2_illegal_reg;

    // Free-running wrap-around branch counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches_reg <= '0;
            stat_taken_reg    <= '0;
        end else if (stat_hit) begin
            stat_branches_reg <= stat_branches_reg + 32'd1;
            if (s2_taken_reg) begin
                stat_taken_reg <= stat_taken_reg + 32'd1;
            end
        end
    end

    assign stat_branches = stat_branches_reg;
    assign stat_taken    = stat_taken_reg;
`endif

endmodule
